// File: rtl/spi_slave_ctrl_pkg.sv
// Shared constants for the SPI-RAM front end: payload width, FSM states and command codes.
package spi_slave_ctrl_pkg;

   localparam int unsigned MEM_WIDTH  = 8;
   localparam int unsigned WORD_WIDTH = MEM_WIDTH + 2;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// SPI pins plus the word/read-data handshake towards the RAM.
// rd_timeout exists only when SPI_RD_TIMEOUT_EN is defined.
interface spi_slave_ctrl_if;
   import spi_slave_ctrl_pkg::*;

   logic                  SS_n;
   logic                  MOSI;
   logic                  MISO;
   logic [WORD_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic [MEM_WIDTH-1:0]  tx_data;
   logic                  tx_valid;
`ifdef SPI_RD_TIMEOUT_EN
   logic                  rd_timeout;

   modport slave (input SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid, rd_timeout);
   modport master (output SS_n, MOSI, tx_data, tx_valid,
                   input MISO, rx_data, rx_valid, rd_timeout);
`else
   modport slave (input SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid);
   modport master (output SS_n, MOSI, tx_data, tx_valid,
                   input MISO, rx_data, rx_valid);
`endif

endinterface

// File: rtl/spi_tx_serializer.sv
// Loads one read-data byte and shifts it out MSB first; done stays set until abort or next load.
module spi_tx_serializer
   import spi_slave_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 abort,
   input  logic [MEM_WIDTH-1:0] data,
   output logic                 miso,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned CNT_W = $clog2(MEM_WIDTH);

   logic [MEM_WIDTH-1:0] sh_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 busy_q;
   logic                 done_q;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (load) begin
         sh_q   <= data;
         cnt_q  <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         sh_q  <= {sh_q[MEM_WIDTH-2:0], 1'b0};
         cnt_q <= cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(MEM_WIDTH - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   assign miso = busy_q & sh_q[MEM_WIDTH-1];
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: assembles 10-bit command words and serialises RAM read data on MISO.
// Optional read-data wait timeout enabled by defining SPI_RD_TIMEOUT_EN.
module spi_slave_ctrl
   import spi_slave_ctrl_pkg::*;
`ifdef SPI_RD_TIMEOUT_EN
#(
   parameter int unsigned TX_TIMEOUT = 15
)
`endif
(
   input logic             clk,
   input logic             rst,
   spi_slave_ctrl_if.slave bus
);

   localparam int unsigned            BIT_CNT_W = $clog2(WORD_WIDTH);
   localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(WORD_WIDTH - 2);

   state_e                  state_q, state_d;
   logic [BIT_CNT_W-1:0]    bit_cnt_q;
   logic [WORD_WIDTH-2:0]   shift_q;
   logic [WORD_WIDTH-1:0]   rx_data_q;
   logic                    rx_valid_q;
   logic                    word_done_q;
   logic                    rd_addr_done_q;
   logic                    data_state;
   logic                    shifting;
   logic                    wait_open;
   logic                    tx_wait;
   logic                    ser_busy, ser_done, ser_miso;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!bus.SS_n) state_d = CHK_CMD;
         CHK_CMD: begin
            if (bus.SS_n)            state_d = IDLE;
            else if (!bus.MOSI)      state_d = WRITE;
            else if (rd_addr_done_q) state_d = READ_DATA;
            else                     state_d = READ_ADD;
         end
         WRITE, READ_ADD, READ_DATA: if (bus.SS_n) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign data_state = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
   assign shifting   = data_state && !word_done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         word_done_q    <= 1'b0;
         rd_addr_done_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (bus.SS_n || state_q == IDLE) begin
            // Leaving or outside a frame: any partial word is dropped.
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            word_done_q <= 1'b0;
         end else begin
            if (state_q == CHK_CMD || shifting) begin
               shift_q <= {shift_q[WORD_WIDTH-3:0], bus.MOSI};
            end
            if (shifting) begin
               bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  rx_data_q   <= {shift_q, bus.MOSI};
                  rx_valid_q  <= 1'b1;
                  word_done_q <= 1'b1;
                  if (state_q == READ_ADD)       rd_addr_done_q <= 1'b1;
                  else if (state_q == READ_DATA) rd_addr_done_q <= 1'b0;
               end
            end
         end
      end
   end

   assign tx_wait = (state_q == READ_DATA) && word_done_q && !bus.SS_n &&
                    !ser_busy && !ser_done && wait_open;

   spi_tx_serializer u_tx_ser (
      .clk   (clk),
      .rst   (rst),
      .load  (tx_wait && bus.tx_valid),
      .abort (bus.SS_n),
      .data  (bus.tx_data),
      .miso  (ser_miso),
      .busy  (ser_busy),
      .done  (ser_done)
   );

`ifdef SPI_RD_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TX_TIMEOUT + 1);

   logic [TO_W-1:0] wait_cnt_q;
   logic            timed_out_q;
   logic            rd_timeout_q;

   always_ff @(posedge clk) begin
      if (rst || bus.SS_n) begin
         wait_cnt_q   <= '0;
         timed_out_q  <= 1'b0;
         rd_timeout_q <= 1'b0;
      end else begin
         rd_timeout_q <= 1'b0;
         if (tx_wait && !bus.tx_valid) begin
            if (wait_cnt_q == TO_W'(TX_TIMEOUT - 1)) begin
               timed_out_q  <= 1'b1;
               rd_timeout_q <= 1'b1;
            end else begin
               wait_cnt_q <= wait_cnt_q + TO_W'(1);
            end
         end
      end
   end

   assign wait_open      = !timed_out_q;
   assign bus.rd_timeout = rd_timeout_q;
`else
   assign wait_open = 1'b1;
`endif

   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.MISO     = ser_miso;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed self-checking bench for spi_slave_ctrl; inputs driven and outputs sampled on negedge.
module tb_spi_slave_ctrl;
   import spi_slave_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   spi_slave_ctrl_if bus ();

   spi_slave_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   // Runs one frame with SS_n low from iteration 0; iteration k drives the bit sampled at edge k.
   // Records observations only; the calling test does the comparisons.
   task automatic run_frame(input logic [9:0] w, input int abort_k, input int tx_k,
                            input logic [7:0] txd, input logic [31:0] stray,
                            output int lat, output logic [9:0] d, output int pulses,
                            output logic [31:0] miso_vec, output logic [31:0] to_vec);
      lat      = -1;
      d        = '0;
      pulses   = 0;
      miso_vec = '0;
      to_vec   = '0;
      @(negedge clk);
      bus.SS_n     = 1'b0;
      bus.MOSI     = 1'b0;
      bus.tx_valid = 1'b0;
      for (int k = 1; k < 32; k++) begin
         @(negedge clk);
         if (bus.rx_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               d   = bus.rx_data;
            end
         end
         miso_vec[k] = bus.MISO;
`ifdef SPI_RD_TIMEOUT_EN
         to_vec[k] = bus.rd_timeout;
`endif
         if (k == abort_k) bus.SS_n = 1'b1;
         bus.MOSI = (k <= 10) ? w[10-k] : k[0];
         if (k == tx_k) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = txd;
         end else if (stray[k]) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'hFF;
         end else begin
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'h00;
         end
      end
   endtask

   task automatic end_frame();
      @(negedge clk);
      bus.SS_n     = 1'b1;
      bus.MOSI     = 1'b0;
      bus.tx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.SS_n     = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.MOSI = i[0];
      end
      @(negedge clk);
      checks++;
      if (bus.rx_data !== 10'h000) begin
         $display("FAIL reset_rx_data: got %h want 000", bus.rx_data); errors++;
      end
      checks++;
      if (bus.rx_valid !== 1'b0) begin
         $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); errors++;
      end
      checks++;
      if (bus.MISO !== 1'b0) begin
         $display("FAIL reset_miso: got %b want 0", bus.MISO); errors++;
      end
      checks++;
      if (dut.state_q !== IDLE) begin
         $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); errors++;
      end
      rst      = 1'b0;
      bus.SS_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_addr();
      int lat, pulses; logic [9:0] d; logic [31:0] mv, tv;
      run_frame(10'b00_1010_0101, -1, -1, 8'h00, 32'h0, lat, d, pulses, mv, tv);
      checks++;
      if (d !== 10'h0A5) begin $display("FAIL wr_addr_data: got %h want 0a5", d); errors++; end
      checks++;
      if (lat !== 11) begin $display("FAIL wr_addr_latency: got %0d want 11", lat); errors++; end
      checks++;
      if (pulses !== 1) begin $display("FAIL wr_addr_pulses: got %0d want 1", pulses); errors++; end
      checks++;
      if (mv !== 32'h0) begin $display("FAIL wr_addr_miso: got %h want 0", mv); errors++; end
      end_frame();
   endtask

   task automatic test_write_data();
      int lat, pulses; logic [9:0] d; logic [31:0] mv, tv;
      run_frame(10'b01_0011_1100, -1, -1, 8'h00, 32'h0, lat, d, pulses, mv, tv);
      checks++;
      if (d !== 10'h13C) begin $display("FAIL wr_data_data: got %h want 13c", d); errors++; end
      checks++;
      if (pulses !== 1) begin $display("FAIL wr_data_pulses: got %0d want 1", pulses); errors++; end
      checks++;
      if (bus.rx_data !== 10'h13C) begin
         $display("FAIL wr_data_hold: got %h want 13c", bus.rx_data); errors++;
      end
      @(negedge clk);
      bus.SS_n = 1'b1;
      @(negedge clk);
      checks++;
      if (dut.state_q !== IDLE) begin
         $display("FAIL wr_data_idle: got %0d want %0d", dut.state_q, IDLE); errors++;
      end
   endtask

   task automatic test_read_pair();
      int lat, pulses; logic [9:0] d; logic [31:0] mv, tv, exp_mv;
      logic [7:0] txd;
      run_frame(10'b10_0000_1111, -1, -1, 8'h00, 32'h0, lat, d, pulses, mv, tv);
      checks++;
      if (d !== 10'h20F) begin $display("FAIL rd_addr_data: got %h want 20f", d); errors++; end
      checks++;
      if (dut.rd_addr_done_q !== 1'b1) begin
         $display("FAIL rd_addr_done_set: got %b want 1", dut.rd_addr_done_q); errors++;
      end
      end_frame();
      checks++;
      if (dut.rd_addr_done_q !== 1'b1) begin
         $display("FAIL rd_addr_done_kept: got %b want 1", dut.rd_addr_done_q); errors++;
      end
      txd    = 8'hC3;
      exp_mv = '0;
      for (int j = 0; j < 8; j++) exp_mv[13+j] = txd[7-j];
      // tx_valid one cycle after rx_valid; stray strobes during the word and after shift-out.
      run_frame(10'b11_0000_0000, -1, 12, txd, 32'h0200_0020, lat, d, pulses, mv, tv);
      checks++;
      if (d !== 10'h300) begin $display("FAIL rd_data_data: got %h want 300", d); errors++; end
      checks++;
      if (lat !== 11) begin $display("FAIL rd_data_latency: got %0d want 11", lat); errors++; end
      checks++;
      if (mv !== exp_mv) begin $display("FAIL rd_data_miso: got %h want %h", mv, exp_mv); errors++; end
      checks++;
      if (dut.rd_addr_done_q !== 1'b0) begin
         $display("FAIL rd_addr_done_clr: got %b want 0", dut.rd_addr_done_q); errors++;
      end
      end_frame();
   endtask

   task automatic test_abort();
      int lat, pulses; logic [9:0] d; logic [31:0] mv, tv;
      run_frame(10'b01_1010_1010, 6, -1, 8'h00, 32'h0, lat, d, pulses, mv, tv);
      checks++;
      if (pulses !== 0) begin $display("FAIL abort_no_valid: got %0d want 0", pulses); errors++; end
      checks++;
      if (bus.rx_data !== 10'h300) begin
         $display("FAIL abort_rx_hold: got %h want 300", bus.rx_data); errors++;
      end
      run_frame(10'b01_1111_0000, -1, -1, 8'h00, 32'h0, lat, d, pulses, mv, tv);
      checks++;
      if (d !== 10'h1F0) begin $display("FAIL abort_next_data: got %h want 1f0", d); errors++; end
      checks++;
      if (lat !== 11) begin $display("FAIL abort_next_latency: got %0d want 11", lat); errors++; end
      end_frame();
   endtask

   task automatic test_mid_reset();
      int lat, pulses; logic [9:0] d; logic [31:0] mv, tv;
      run_frame(10'b10_0101_0101, -1, -1, 8'h00, 32'h0, lat, d, pulses, mv, tv);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (dut.rd_addr_done_q !== 1'b0) begin
         $display("FAIL midrst_rd_addr_done: got %b want 0", dut.rd_addr_done_q); errors++;
      end
      checks++;
      if (bus.rx_data !== 10'h000) begin
         $display("FAIL midrst_rx_data: got %h want 000", bus.rx_data); errors++;
      end
      rst      = 1'b0;
      bus.SS_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef SPI_RD_TIMEOUT_EN
   task automatic test_timeout();
      int lat, pulses; logic [9:0] d; logic [31:0] mv, tv;
      run_frame(10'b10_0000_0001, -1, -1, 8'h00, 32'h0, lat, d, pulses, mv, tv);
      end_frame();
      run_frame(10'b11_0000_0001, -1, -1, 8'h00, 32'h0, lat, d, pulses, mv, tv);
      checks++;
      if (tv !== 32'h0400_0000) begin
         $display("FAIL timeout_pulse: got %h want 04000000", tv); errors++;
      end
      checks++;
      if (mv !== 32'h0) begin $display("FAIL timeout_miso: got %h want 0", mv); errors++; end
      end_frame();
   endtask
`endif

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.SS_n     = 1'b1;
      bus.MOSI     = 1'b0;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      test_reset();
      test_write_addr();
      test_write_data();
      test_read_pair();
      test_abort();
      test_mid_reset();
`ifdef SPI_RD_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- Serial front end of the SPI-RAM subsystem; sits directly upstream of the RAM.
- Deserialises MOSI into 10-bit command words (2-bit cmd + MEM_WIDTH payload) and presents them on rx_data/rx_valid.
- For read-data commands, accepts the RAM's tx_data/tx_valid and serialises it MSB-first on MISO.
- Five-state FSM: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.

Parameters:
- MEM_WIDTH, 8: payload width; rx_data is MEM_WIDTH+2 bits.
- TX_TIMEOUT, 15: cycles to wait for tx_valid. Used only with SPI_RD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; SPI bit clock, one bit per rising edge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  MEM_WIDTH+2  assembled word {cmd[1:0], payload}; cmd 00=wr addr, 01=wr data, 10=rd addr, 11=rd data.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  MEM_WIDTH  read data from RAM.
- tx_valid  input  1  tx_data valid strobe.
- rd_timeout  output  1  only with SPI_RD_TIMEOUT_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports clk, rst.
- Reset values: state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, shift regs=0, rd_addr_done=0.
- IDLE: SS_n sampled low -> CHK_CMD. Otherwise stay.
- CHK_CMD: sampled MOSI is word bit 9 and is stored.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_done=0 -> READ_ADD.
  - MOSI=1 and rd_addr_done=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift bits 8..0 over the next 9 cycles.
  - The cycle after the 9th bit: rx_data = full word, rx_valid=1 for exactly one cycle.
  - rx_data holds until the next completed word.
- Total latency: SS_n low edge to rx_valid = 11 cycles.
- rd_addr_done:
  - Set when a READ_ADD word completes.
  - Cleared when a READ_DATA word completes.
  - Not cleared by SS_n; cleared by rst only.
- The word is forwarded as received. A cmd value inconsistent with the state is not filtered; the RAM decodes it.
- After the word completes in WRITE or READ_ADD: further MOSI bits are ignored; stay until SS_n high.
- READ_DATA after its rx_valid:
  - Wait for tx_valid; latch tx_data on the cycle tx_valid=1.
  - MISO drives bits MEM_WIDTH-1..0 on the next MEM_WIDTH cycles, one per cycle.
  - MISO=0 afterwards.
  - tx_valid outside this wait window is ignored.
- SS_n high in any non-IDLE state -> IDLE next cycle.
  - Counter cleared; partial word discarded; no rx_valid; MISO=0.
  - A serialisation in progress is aborted.
- rst mid-frame overrides everything: immediate return to reset values.
- SS_n low held continuously after a frame ends does not start a new frame. A new frame needs SS_n to go high at least one cycle, then low.

Optional Feature:
- Macro: SPI_RD_TIMEOUT_EN.
- Defined: while waiting for tx_valid in READ_DATA, count cycles.
  - Reaching TX_TIMEOUT with no tx_valid: rd_timeout=1 for one cycle, MISO stays 0.
  - FSM stays in READ_DATA (no serialisation) until SS_n high.
- Undefined: rd_timeout port and counter are absent; wait is unbounded.

Decomposition:
- shared_pkg holds:
  - MEM_WIDTH.
  - State enum IDLE/CHK_CMD/WRITE/READ_ADD/READ_DATA (existing constants).
  - Command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- One sub-module, spi_tx_serializer: load on tx_valid, MEM_WIDTH-bit shift-out, done flag, abort input.

Test Plan:
- Reset: rst=1 two cycles with MOSI toggling -> all outputs 0, state IDLE.
- Write address: SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5, rx_valid one cycle, 11 cycles after SS_n fall; MISO=0 throughout.
- Write data: 01_0011_1100 -> rx_data=10'h13C. Then SS_n high -> IDLE next cycle.
- Read pair: frame 10_0000_1111 -> rx_data=10'h20F, rd_addr_done=1. Next frame CHK_CMD routes to READ_DATA; word 11_0000_0000 -> rx_data=10'h300. Drive tx_data=8'hC3, tx_valid one cycle later -> MISO 1,1,0,0,0,0,1,1 on the following 8 cycles; rd_addr_done=0.
- Abort: SS_n high after 5 bits of a write frame -> no rx_valid; next full frame 01_1111_0000 -> rx_data=10'h1F0.
- Timeout (SPI_RD_TIMEOUT_EN, TX_TIMEOUT=15): read-data frame, tx_valid never asserted -> rd_timeout pulse 15 cycles after rx_valid, MISO=0.
